// File: rtl/sorter_pkg.sv
// Shared constants for the V2V bit sorter control path: mode codes,
// FSM state encoding, strobe bit positions and small decode helpers.
package sorter_pkg;

    localparam logic [1:0] M_QPSK  = 2'b00;
    localparam logic [1:0] M_QAM16 = 2'b01;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD_I = 2'd1;
    localparam logic [1:0] S_LOAD_Q = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam int unsigned LOAD_I_BIT = 0;
    localparam int unsigned LOAD_Q_BIT = 1;

    // Holds STEPS-1 for STEPS up to 15.
    localparam int unsigned CNT_W = 4;

    function automatic logic mode_legal(input logic [1:0] m);
        return (m == M_QPSK) || (m == M_QAM16);
    endfunction

    function automatic logic [1:0] strobe_vec(input logic [1:0] st);
        logic [1:0] v;
        v = 2'b00;
        case (st)
            S_LOAD_I: v[LOAD_I_BIT] = 1'b1;
            S_LOAD_Q: v[LOAD_Q_BIT] = 1'b1;
            default:  v = 2'b00;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/ctrl_unit_sorter.sv
// Control FSM sequencing I/Q load strobes for QPSK / 16-QAM symbols.
// Optional registered busy output enabled by defining SORTER_BUSY_EN.
module ctrl_unit_sorter
    import sorter_pkg::*;
#(
    parameter int unsigned QPSK_STEPS  = 1,
    parameter int unsigned QAM16_STEPS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] M,
    input  logic       start,
    output logic       done,
    output logic [1:0] loadQPSK,
`ifdef SORTER_BUSY_EN
    output logic [1:0] loadQAM16,
    output logic       busy
`else
    output logic [1:0] loadQAM16
`endif
);

    localparam logic [CNT_W-1:0] QPSK_M1  = CNT_W'(QPSK_STEPS - 1);
    localparam logic [CNT_W-1:0] QAM16_M1 = CNT_W'(QAM16_STEPS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic             done_q, done_d;
    logic [1:0]       load_qpsk_q, load_qpsk_d;
    logic [1:0]       load_qam16_q, load_qam16_d;
    logic             accept_s;
    logic [CNT_W-1:0] steps_m1_s;
    logic [1:0]       strobe_s;

    // Next-state, step counter and mode latch; outputs decode the next state so they register in step with it.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mode_d       = mode_q;
        accept_s     = start && mode_legal(M);
        steps_m1_s   = (mode_q == M_QAM16) ? QAM16_M1 : QPSK_M1;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = S_LOAD_I;
                    mode_d  = M;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD_I: begin
                if (cnt_q == steps_m1_s) begin
                    state_d = S_LOAD_Q;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_LOAD_Q: begin
                if (cnt_q == steps_m1_s) begin
                    state_d = S_DONE;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DONE: begin
                if (accept_s) begin
                    state_d = S_LOAD_I;
                    mode_d  = M;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase

        strobe_s = strobe_vec(state_d);
        if (mode_d == M_QAM16) begin
            load_qam16_d = strobe_s;
            load_qpsk_d  = 2'b00;
        end else begin
            load_qam16_d = 2'b00;
            load_qpsk_d  = strobe_s;
        end
        done_d = (state_d == S_DONE);
    end

    // State and registered outputs with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            mode_q       <= M_QPSK;
            done_q       <= 1'b0;
            load_qpsk_q  <= 2'b00;
            load_qam16_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mode_q       <= mode_d;
            done_q       <= done_d;
            load_qpsk_q  <= load_qpsk_d;
            load_qam16_q <= load_qam16_d;
        end
    end

    assign done      = done_q;
    assign loadQPSK  = load_qpsk_q;
    assign loadQAM16 = load_qam16_q;

`ifdef SORTER_BUSY_EN
    logic busy_q, busy_d;

    // Busy covers every non-idle state, registered alongside the FSM.
    always_comb begin
        busy_d = (state_d != S_IDLE);
    end

    // Busy flop with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;
`endif

endmodule

// File: tb/tb_ctrl_unit_sorter.sv
// Scoreboard bench for ctrl_unit_sorter: stimulus pushes cycle-stamped
// expected output events, a negedge monitor pops and compares them.
module tb_ctrl_unit_sorter;

    logic       clk;
    logic       rst;
    logic [1:0] M;
    logic       start;
    logic       done;
    logic [1:0] loadQPSK;
    logic [1:0] loadQAM16;
`ifdef SORTER_BUSY_EN
    logic       busy;
`endif

    ctrl_unit_sorter dut (
        .clk       (clk),
        .rst       (rst),
        .M         (M),
        .start     (start),
        .done      (done),
        .loadQPSK  (loadQPSK),
`ifdef SORTER_BUSY_EN
        .loadQAM16 (loadQAM16),
        .busy      (busy)
`else
        .loadQAM16 (loadQAM16)
`endif
    );

    typedef struct {
        int         cyc;
        logic       done;
        logic [1:0] lq;
        logic [1:0] l16;
    } exp_t;

    exp_t exp_q[$];
    int   cyc        = 0;
    int   checks     = 0;
    int   failures   = 0;
    int   exp_dones  = 0;
    int   dones_seen = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Expected output cycles for one accepted symbol whose accept edge is e (defaults: QPSK 1 step, 16-QAM 2 steps).
    task automatic push_seq(input int e, input logic [1:0] m);
        int   steps;
        exp_t x;
        steps = (m == 2'b01) ? 2 : 1;
        for (int i = 0; i < 2 * steps; i++) begin
            logic [1:0] v;
            v = (i < steps) ? 2'b01 : 2'b10;
            x.cyc  = e + i;
            x.done = 1'b0;
            x.lq   = (m == 2'b01) ? 2'b00 : v;
            x.l16  = (m == 2'b01) ? v : 2'b00;
            exp_q.push_back(x);
        end
        x.cyc  = e + 2 * steps;
        x.done = 1'b1;
        x.lq   = 2'b00;
        x.l16  = 2'b00;
        exp_q.push_back(x);
        exp_dones++;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (done !== 1'b0 || loadQPSK !== 2'b00 || loadQAM16 !== 2'b00) begin
            failures++;
            $display("FAIL %s got done=%b qpsk=%b qam16=%b required all zero",
                     name, done, loadQPSK, loadQAM16);
        end
    endtask

    // Monitor: any active output must match the head of the scoreboard; overdue entries are misses.
    always @(negedge clk) begin
        exp_t ex;
        if (done === 1'b1 || (loadQPSK !== 2'b00 && loadQPSK !== 2'bxx) ||
            (loadQAM16 !== 2'b00 && loadQAM16 !== 2'bxx)) begin
            checks++;
            if (done === 1'b1) dones_seen++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output cyc=%0d got done=%b qpsk=%b qam16=%b required idle",
                         cyc, done, loadQPSK, loadQAM16);
            end else begin
                ex = exp_q.pop_front();
                if (ex.cyc != cyc || ex.done !== done || ex.lq !== loadQPSK || ex.l16 !== loadQAM16) begin
                    failures++;
                    $display("FAIL output_event got cyc=%0d done=%b qpsk=%b qam16=%b required cyc=%0d done=%b qpsk=%b qam16=%b",
                             cyc, done, loadQPSK, loadQAM16, ex.cyc, ex.done, ex.lq, ex.l16);
                end
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            checks++;
            failures++;
            ex = exp_q.pop_front();
            $display("FAIL missing_output cyc=%0d got idle required done=%b qpsk=%b qam16=%b",
                     cyc, ex.done, ex.lq, ex.l16);
        end
    end

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        M     = 2'b00;
        #1 rst = 1'b1;
        #1 check_zero("reset_state");
        tick(2);
        rst = 1'b0;
        tick(1);

        // QPSK single symbol
        M = 2'b00; start = 1'b1; push_seq(cyc + 1, 2'b00);
        tick(1); start = 1'b0;
        tick(4);

        // 16-QAM single symbol
        M = 2'b01; start = 1'b1; push_seq(cyc + 1, 2'b01);
        tick(1); start = 1'b0;
        tick(6);

        // Back-to-back QPSK with start held through DONE
        M = 2'b00; start = 1'b1;
        push_seq(cyc + 1, 2'b00);
        push_seq(cyc + 4, 2'b00);
        tick(4); start = 1'b0;
        tick(5);

        // start held during LOAD_I/LOAD_Q of a 16-QAM symbol is ignored
        M = 2'b01; start = 1'b1; push_seq(cyc + 1, 2'b01);
        tick(1);
        tick(3); start = 1'b0;
        tick(6);

        // M changed mid-QPSK has no effect
        M = 2'b00; start = 1'b1; push_seq(cyc + 1, 2'b00);
        tick(1); start = 1'b0; M = 2'b01;
        tick(5);

        // Reserved modes are ignored
        M = 2'b10; start = 1'b1;
        tick(3);
        M = 2'b11;
        tick(1); start = 1'b0;
        tick(2);

        // Reset during 16-QAM LOAD_Q aborts the symbol
        M = 2'b01; start = 1'b1; push_seq(cyc + 1, 2'b01);
        tick(1); start = 1'b0;
        tick(2);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_zero("reset_abort");
        exp_q.delete();
        exp_dones--;
        tick(2);
        check_zero("reset_held");
        rst = 1'b0;
        tick(1);
        M = 2'b01; start = 1'b1; push_seq(cyc + 1, 2'b01);
        tick(1); start = 1'b0;
        tick(7);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
        end
        checks++;
        if (dones_seen != exp_dones) begin
            failures++;
            $display("FAIL done_count got %0d required %0d", dones_seen, exp_dones);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got no finish required finish");
        $fatal(1);
    end

endmodule

// File: doc/ctrl_unit_sorter.md
Name: ctrl_unit_sorter

Overview:
- Control FSM for the V2V bit sorter.
- On a start pulse, it sequences load strobes that steer incoming bits into the I/Q symbol registers of the datapath. The strobe pattern depends on the modulation order M: QPSK or 16-QAM.
- Emits a one-cycle done pulse when the symbol is complete.
- Sits between the transmitter front-end (which issues start and M) and the sorter datapath registers.

Parameters:
- QPSK_STEPS, default 1: strobe cycles per axis (I, then Q) in QPSK mode; legal range 1..15.
- QAM16_STEPS, default 2: strobe cycles per axis (I, then Q) in 16-QAM mode; legal range 1..15.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- M, input, 2: modulation select. 2'b00 = QPSK, 2'b01 = 16-QAM, 2'b10 and 2'b11 reserved. Sampled only when start is accepted.
- start, input, 1: request to sort one symbol; level-sampled on the rising edge.
- done, output, 1: one-cycle pulse when the symbol sequence is finished.
- loadQPSK, output, 2: bit [0] = load I register, bit [1] = load Q register (QPSK path).
- loadQAM16, output, 2: bit [0] = shift-load I register, bit [1] = shift-load Q register (16-QAM path).

Behaviour:
- All outputs are registered. Reset forces state IDLE, done=0, loadQPSK=2'b00, loadQAM16=2'b00 and clears the step counter and the mode latch immediately (asynchronous).
- States: IDLE, LOAD_I, LOAD_Q, DONE.
- IDLE:
  - If start=1 and M is 00 or 01: latch M into the mode register, clear the step counter, go to LOAD_I.
  - If start=1 and M is reserved: ignore it and stay in IDLE.
- LOAD_I:
  - Assert bit [0] of the vector selected by the latched mode; the other vector stays 00.
  - Stay for STEPS cycles (QPSK_STEPS or QAM16_STEPS), then clear the counter and go to LOAD_Q.
- LOAD_Q:
  - Same as LOAD_I, but assert bit [1]. After STEPS cycles, go to DONE.
- DONE:
  - done=1 for exactly one cycle; all strobes are 0.
  - Next state is LOAD_I if start=1 with a legal M (back-to-back symbol, new M latched); otherwise IDLE.
- Latency with defaults, counting from the edge that samples start=1:
  - QPSK: first strobe visible after that edge; done visible 3 cycles after that edge.
  - 16-QAM: done visible 5 cycles after that edge.
- start=1 while in LOAD_I or LOAD_Q is ignored and not queued.
- A change of M during a sequence has no effect; the latched mode governs.
- Never more than one strobe bit is high in any cycle. loadQPSK and loadQAM16 are never both non-zero.
- Reset asserted mid-sequence aborts it. No done pulse is produced for the aborted symbol.
- The step counter is wide enough for STEPS-1 and never wraps within a phase.

Optional Feature:
- Macro SORTER_BUSY_EN.
- When defined: adds output port busy (1 bit), registered. busy=1 in LOAD_I, LOAD_Q and DONE; busy=0 in IDLE and during reset.
- When undefined: the port does not exist and the logic is identical otherwise.

Decomposition:
- Shared package sorter_pkg holds:
  - mode constants M_QPSK=2'b00 and M_QAM16=2'b01;
  - the FSM state encoding (IDLE, LOAD_I, LOAD_Q, DONE);
  - the strobe bit indices LOAD_I_BIT=0 and LOAD_Q_BIT=1.
- No sub-module. Step counter and FSM live in one module.

Test Plan:
- Reset: assert rst mid-cycle. Outputs must be 0 before the next edge; state is IDLE.
- QPSK: M=00, one-cycle start. Required output cycles: loadQPSK=01, then 10, then done=1, then idle. loadQAM16 stays 00 throughout.
- 16-QAM: M=01, one-cycle start. Required output cycles: loadQAM16=01, 01, 10, 10, then done=1. loadQPSK stays 00.
- Back-to-back: start held high through DONE with M=00. The sequence restarts with loadQPSK=01 in the cycle after done, with no IDLE gap.
- Robustness:
  - start pulses during LOAD_I and LOAD_Q must be ignored, giving exactly one done per accepted start.
  - M switched to 01 mid-QPSK must not alter the strobe pattern.
  - M=10 with start must stay IDLE with no strobes.
- Reset abort: rst asserted during the 16-QAM LOAD_Q phase. Outputs go to 0 immediately, with no done pulse. A new start after reset release must run a full sequence.
